// File: rtl/fre_pkg.sv
// Shared definitions for the P[d] metric estimator.
//   DW        : component width of the 1.15 I/Q samples
//   IN_FRAC   : fractional bits of an input sample (1.15)
//   OUT_FRAC  : fractional bits of the reported metric (2.14)
//   SAT_IN_W  : width of the value handed to sat16()
//   fre_state_e : burst FSM states
package fre_pkg;

  localparam int DW       = 16;
  localparam int IN_FRAC  = 15;
  localparam int OUT_FRAC = 14;
  localparam int SAT_IN_W = 48;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    REPORT = 2'd2,
    DONE   = 2'd3
  } fre_state_e;

  localparam logic signed [SAT_IN_W-1:0] SAT_MAX = 48'sd32767;
  localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -48'sd32768;

  // Clamp a wide signed value into a 16-bit signed word.
  function automatic logic signed [DW-1:0] sat16(input logic signed [SAT_IN_W-1:0] v);
    if (v > SAT_MAX) begin
      return 16'sh7FFF;
    end else if (v < SAT_MIN) begin
      return 16'sh8000;
    end else begin
      return v[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/fre_delay_line.sv
// Fixed-depth delay line with enable and synchronous clear.
//   CLK_I : clock
//   en    : shift one position (din enters, oldest leaves)
//   clr   : synchronous clear of every tap (wins over en)
//   din   : word entering the line
//   dout  : word that entered DEPTH enables ago; zero until the line is filled
module fre_delay_line #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic             CLK_I,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK_I) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/fre_pmetric_est.sv
// P[d] autocorrelation metric producer with Wishbone pass-through.
// Computes P = (1/WIN) * sum r[n]*conj(r[n-LAG]) over the first LAG+WIN samples
// of each burst and reports it once as a 2.14 complex word.
//   CLK_I, RST_I (sync, active-low)
//   DAT_I/WE_I/STB_I/CYC_I/ACK_O : slave side, samples Im[31:16] Re[15:0] 1.15
//   DAT_O/CYC_O/STB_O/WE_O/ACK_I : master side, 1-cycle registered pass-through
//   FRE_O    : metric Im[31:16] Re[15:0] 2.14, held until the next report
//   FRE_O_nd : one-cycle strobe marking a new FRE_O
module fre_pmetric_est
  import fre_pkg::*;
#(
  parameter int LAG   = 64,
  parameter int WIN   = 64,
  parameter int ACC_W = 2*DW + 1 + $clog2(WIN)
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        WE_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  output logic        ACK_O,
  output logic [31:0] DAT_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I,
  output logic [31:0] FRE_O,
  output logic        FRE_O_nd
);

  localparam int PW    = 2*DW + 1;
  localparam int SHIFT = $clog2(WIN) + (2*IN_FRAC - OUT_FRAC);
  localparam int NTOT  = LAG + WIN;
  localparam int CW    = $clog2(NTOT + 1);

  function automatic logic signed [PW-1:0] ext_p(input logic signed [DW-1:0] v);
    return {{(PW-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] ext_acc(input logic signed [PW-1:0] v);
    return {{(ACC_W-PW){v[PW-1]}}, v};
  endfunction

  // Divide by WIN and drop to 2.14 (floor), then clamp to 16 bits.
  function automatic logic signed [DW-1:0] scale_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    sh = a >>> SHIFT;
    return sat16({{(SAT_IN_W-ACC_W){sh[ACC_W-1]}}, sh});
  endfunction

  logic       halt, accept, burst_end, dl_clr;
  fre_state_e state_q, state_d;

  assign halt      = STB_O & ~ACK_I;
  assign accept    = CYC_I & STB_I & WE_I & ~halt;
  assign ACK_O     = accept;
  assign WE_O      = STB_O;
  assign burst_end = ~CYC_I & ~STB_O;
  assign dl_clr    = ~RST_I | burst_end;

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      DAT_O <= '0;
      STB_O <= 1'b0;
      CYC_O <= 1'b0;
    end else begin
      if (!halt) begin
        DAT_O <= DAT_I;
        STB_O <= accept;
      end
      if (accept)         CYC_O <= 1'b1;
      else if (burst_end) CYC_O <= 1'b0;
    end
  end

  // Stage 0: current sample against the one accepted LAG samples earlier.
  logic [31:0]          smp_d;
  logic signed [DW-1:0] xr, xi, dr, di;
  logic signed [PW-1:0] pr_c, pi_c;

  fre_delay_line #(.DEPTH(LAG), .WIDTH(32)) u_smp_dl (
    .CLK_I (CLK_I),
    .en    (accept),
    .clr   (dl_clr),
    .din   (DAT_I),
    .dout  (smp_d)
  );

  assign xr   = DAT_I[DW-1:0];
  assign xi   = DAT_I[31:16];
  assign dr   = smp_d[DW-1:0];
  assign di   = smp_d[31:16];
  assign pr_c = ext_p(xr) * ext_p(dr) + ext_p(xi) * ext_p(di);
  assign pi_c = ext_p(xi) * ext_p(dr) - ext_p(xr) * ext_p(di);

  // Stage 1: registered conjugate product.
  logic signed [PW-1:0] pr_p1, pi_p1;
  logic                 vld_p1, last_p1;
  logic [CW-1:0]        cnt;

  always_ff @(posedge CLK_I) begin
    if (!RST_I || burst_end) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      cnt     <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        last_p1 <= (cnt == CW'(NTOT - 1));
        if (cnt != CW'(NTOT)) cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (accept) begin
      pr_p1 <= pr_c;
      pi_p1 <= pi_c;
    end
  end

  // Stage 2: sliding window sum; the product leaving the window is subtracted.
  logic [2*PW-1:0]         pold;
  logic signed [PW-1:0]    pold_r, pold_i;
  logic signed [ACC_W-1:0] acc_re_p2, acc_im_p2, acc_re_nxt, acc_im_nxt;
  logic                    rpt_hit;

  fre_delay_line #(.DEPTH(WIN), .WIDTH(2*PW)) u_prod_dl (
    .CLK_I (CLK_I),
    .en    (vld_p1),
    .clr   (dl_clr),
    .din   ({pr_p1, pi_p1}),
    .dout  (pold)
  );

  assign pold_r     = pold[2*PW-1:PW];
  assign pold_i     = pold[PW-1:0];
  assign acc_re_nxt = acc_re_p2 + ext_acc(pr_p1) - ext_acc(pold_r);
  assign acc_im_nxt = acc_im_p2 + ext_acc(pi_p1) - ext_acc(pold_i);
  assign rpt_hit    = vld_p1 & last_p1 & (state_q == FILL);

  always_ff @(posedge CLK_I) begin
    if (!RST_I || burst_end) begin
      acc_re_p2 <= '0;
      acc_im_p2 <= '0;
    end else if (vld_p1) begin
      acc_re_p2 <= acc_re_nxt;
      acc_im_p2 <= acc_im_nxt;
    end
  end

  // Report is taken from the sum that includes the closing sample.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      FRE_O    <= '0;
      FRE_O_nd <= 1'b0;
    end else begin
      FRE_O_nd <= rpt_hit;
      if (rpt_hit) FRE_O <= {scale_sat(acc_im_nxt), scale_sat(acc_re_nxt)};
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FILL;
      FILL:    if (rpt_hit) state_d = REPORT;
      REPORT:  state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (burst_end) state_d = IDLE;
  end

endmodule

// File: tb/tb_fre_pmetric_est.sv
module tb_fre_pmetric_est;

  localparam int LAG  = 64;
  localparam int WIN  = 64;
  localparam int NTOT = LAG + WIN;

  localparam int G_C4000 = 0;
  localparam int G_PH    = 1;
  localparam int G_7FFF  = 2;
  localparam int G_RAND  = 3;
  localparam int G_8000  = 4;

  localparam int S_NONE   = 0;
  localparam int S_STALL5 = 1;
  localparam int S_RAND   = 2;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [31:0] DAT_I;
  logic        WE_I, STB_I, CYC_I, ACK_I;
  logic        ACK_O, CYC_O, STB_O, WE_O, FRE_O_nd;
  logic [31:0] DAT_O, FRE_O;

  fre_pmetric_est dut (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .DAT_I    (DAT_I),
    .WE_I     (WE_I),
    .STB_I    (STB_I),
    .CYC_I    (CYC_I),
    .ACK_O    (ACK_O),
    .DAT_O    (DAT_O),
    .CYC_O    (CYC_O),
    .STB_O    (STB_O),
    .WE_O     (WE_O),
    .ACK_I    (ACK_I),
    .FRE_O    (FRE_O),
    .FRE_O_nd (FRE_O_nd)
  );

  always #5 CLK_I = ~CLK_I;

  int          n_pass = 0;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc_n  = 0;
  logic [31:0] pass_q[$];
  int          br[$];
  int          bi[$];
  int          exp_cyc;
  logic [31:0] exp_fre;
  logic [31:0] model_fre = 32'h0;
  bit          pending;
  int          nd_cnt;
  bit          last_ack;
  bit          prev_halt = 1'b0;
  logic [31:0] prev_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat(input longint v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  // Reference: mean of r[n]*conj(r[n-LAG]) over n = LAG .. LAG+WIN-1, 2.14 floor.
  function automatic logic [31:0] model_p();
    longint sr, si;
    sr = 0;
    si = 0;
    for (int n = LAG; n < NTOT; n++) begin
      sr += longint'(br[n]) * br[n-LAG] + longint'(bi[n]) * bi[n-LAG];
      si += longint'(bi[n]) * br[n-LAG] - longint'(br[n]) * bi[n-LAG];
    end
    sr = sr >>> ($clog2(WIN) + 16);
    si = si >>> ($clog2(WIN) + 16);
    return {sat(si), sat(sr)};
  endfunction

  function automatic logic [31:0] gen(input int g, input int k);
    real ph;
    int  re, im;
    case (g)
      G_C4000: return 32'h0000_4000;
      G_7FFF:  return 32'h0000_7FFF;
      G_8000:  return 32'h8000_8000;
      G_PH: begin
        ph = 3.14159265358979 * k / 128.0;
        re = $rtoi($floor(16384.0 * $cos(ph) + 0.5));
        im = $rtoi($floor(16384.0 * $sin(ph) + 0.5));
        return {im[15:0], re[15:0]};
      end
      default: return $urandom;
    endcase
  endfunction

  // One clock: observe at the falling edge, then advance past the rising edge.
  task automatic tick();
    logic [31:0]        exp_d;
    logic signed [15:0] t;
    @(negedge CLK_I);
    cyc_n++;
    if (prev_halt) begin
      chk("hold_dat", DAT_O, prev_dat);
      chk("hold_stb", {31'b0, STB_O}, 32'd1);
    end
    if (STB_O && !ACK_I) chk("halt_ack", {31'b0, ACK_O}, 32'd0);
    if (STB_O && ACK_I) begin
      chk("pass_avail", {31'b0, pass_q.size() != 0}, 32'd1);
      if (pass_q.size() != 0) begin
        exp_d = pass_q.pop_front();
        chk("pass_dat", DAT_O, exp_d);
      end
    end
    last_ack = (ACK_O === 1'b1);
    if (last_ack) begin
      pass_q.push_back(DAT_I);
      if (br.size() < NTOT) begin
        t = DAT_I[15:0];
        br.push_back(int'(t));
        t = DAT_I[31:16];
        bi.push_back(int'(t));
        if (br.size() == NTOT) begin
          exp_fre   = model_p();
          model_fre = exp_fre;
          exp_cyc   = cyc_n + 2;
          pending   = 1'b1;
        end
      end
    end
    if (FRE_O_nd === 1'b1) begin
      nd_cnt++;
      chk("nd_cycle", 32'(cyc_n), pending ? 32'(exp_cyc) : 32'hFFFF_FFFF);
      chk("fre_val", FRE_O, exp_fre);
      pending = 1'b0;
    end
    prev_halt = (STB_O === 1'b1) && (ACK_I === 1'b0);
    prev_dat  = DAT_O;
    @(posedge CLK_I);
    #1;
  endtask

  task automatic run_burst(input int n, input int g, input int s, input bit do_rst);
    int idx;
    int bc;
    idx = 0;
    bc  = 0;
    br.delete();
    bi.delete();
    pending = 1'b0;
    nd_cnt  = 0;
    while (idx < n && bc < n * 8 + 100) begin
      CYC_I = 1'b1;
      WE_I  = (s == S_RAND) ? ($urandom_range(0, 7) != 0) : 1'b1;
      STB_I = (s == S_RAND) ? ($urandom_range(0, 4) != 0) : 1'b1;
      DAT_I = gen(g, idx);
      if (s == S_STALL5)    ACK_I = !(bc >= 60 && bc < 65);
      else if (s == S_RAND) ACK_I = ($urandom_range(0, 3) != 0);
      else                  ACK_I = 1'b1;
      tick();
      if (last_ack) idx++;
      bc++;
    end
    chk("burst_sent", 32'(idx), 32'(n));
    STB_I = 1'b0;
    WE_I  = 1'b0;
    ACK_I = 1'b1;
    if (do_rst) begin
      CYC_I = 1'b0;
      RST_I = 1'b0;
      tick();
      RST_I = 1'b1;
      chk("rst_dat", DAT_O, 32'h0);
      chk("rst_fre", FRE_O, 32'h0);
      chk("rst_ctl", {28'b0, CYC_O, STB_O, WE_O, FRE_O_nd}, 32'h0);
      chk("rst_nd_count", 32'(nd_cnt), 32'd0);
      pass_q.delete();
      br.delete();
      bi.delete();
      pending   = 1'b0;
      model_fre = 32'h0;
      prev_halt = 1'b0;
      repeat (2) tick();
    end else begin
      repeat (4) tick();
      CYC_I = 1'b0;
      repeat (3) tick();
      chk("drain", 32'(pass_q.size()), 32'd0);
      chk("nd_count", 32'(nd_cnt), (n >= NTOT) ? 32'd1 : 32'd0);
      chk("cyc_o_low", {31'b0, CYC_O}, 32'd0);
      chk("fre_hold", FRE_O, model_fre);
    end
  endtask

  initial begin
    logic signed [15:0] v;
    RST_I = 1'b0;
    DAT_I = 32'h0;
    WE_I  = 1'b0;
    STB_I = 1'b0;
    CYC_I = 1'b0;
    ACK_I = 1'b1;
    repeat (2) tick();
    chk("init_dat", DAT_O, 32'h0);
    chk("init_fre", FRE_O, 32'h0);
    chk("init_ctl", {28'b0, CYC_O, STB_O, WE_O, FRE_O_nd}, 32'h0);
    RST_I = 1'b1;
    repeat (2) tick();

    run_burst(200, G_C4000, S_NONE, 1'b0);
    chk("t1_const", FRE_O, 32'h0000_1000);

    run_burst(200, G_PH, S_NONE, 1'b0);
    v = FRE_O[15:0];
    chk("t2_re_tol", {31'b0, (v >= -2 && v <= 2)}, 32'd1);
    v = FRE_O[31:16];
    chk("t2_im_tol", {31'b0, (v >= 16'sh0FFE && v <= 16'sh1002)}, 32'd1);

    run_burst(200, G_7FFF, S_NONE, 1'b0);

    run_burst(200, G_C4000, S_STALL5, 1'b0);
    chk("t4_stall", FRE_O, 32'h0000_1000);

    run_burst(50, G_RAND, S_NONE, 1'b0);
    run_burst(200, G_RAND, S_NONE, 1'b0);

    run_burst(90, G_C4000, S_NONE, 1'b1);
    run_burst(200, G_C4000, S_NONE, 1'b0);
    chk("t6_after_rst", FRE_O, 32'h0000_1000);

    run_burst(200, G_8000, S_NONE, 1'b0);
    chk("sat_pos", FRE_O, 32'h0000_7FFF);

    for (int b = 0; b < 3; b++) begin
      run_burst(130 + $urandom_range(0, 60), G_RAND, S_RAND, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
